// File: rtl/numb2str.sv
// numb2str: binary to character-string converter (decimal or hex).
// Ports: clk, rst, start, value -> busy, done, overflow; char_idx -> char_code.
// Option: LEADING_ZERO_BLANK_EN blanks zeros left of the first nonzero digit.
`timescale 1ns/1ps
module numb2str #(
  parameter int WIDTH = 16,
  parameter int NDIGITS = 5,
  parameter int HEX = 0,
  parameter logic [6:0] DIGIT0_CODE = 7'h30,
  parameter logic [6:0] ALPHA_CODE = 7'h41,
  parameter logic [6:0] SPACE_CODE = 7'h20,
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  input  logic [IW-1:0]    char_idx,
  output logic [6:0]       char_code
);

  localparam int BW = 4 * NDIGITS;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] LOAD    = 2'd2;

  logic [1:0]          state;
  logic [WIDTH-1:0]    shreg;
  logic [BW-1:0]       bcd;
  logic [BW-1:0]       adj;
  logic [BW-1:0]       dbuf;
  logic [CW-1:0]       cnt;
  logic                ovp;
  logic [WIDTH+BW-1:0] ext;
  logic [NDIGITS-1:0]  blank;
  logic [3:0]          dsel;
  logic                bsel;
  logic                inrng;
  logic [6:0]          code_nxt;

  assign busy = (state == CONVERT);
  assign done = (state == LOAD);

  // Zero-extended capture; bits at or above BW cannot be shown in hex.
  assign ext = {{BW{1'b0}}, shreg};

  // Add-3 to every BCD digit >= 5 before the shift.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovp      <= 1'b0;
      dbuf     <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= value;
            bcd   <= '0;
            ovp   <= 1'b0;
            cnt   <= CW'(WIDTH - 1);
            state <= CONVERT;
          end
        end
        CONVERT: begin
          if (HEX != 0) begin
            bcd   <= ext[BW-1:0];
            ovp   <= |ext[WIDTH+BW-1:BW];
            state <= LOAD;
          end else begin
            // Top bit leaving the BCD field means the value needs more digits.
            bcd   <= {adj[BW-2:0], shreg[WIDTH-1]};
            ovp   <= ovp | adj[BW-1];
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            cnt   <= cnt - 1'b1;
            if (cnt == '0)
              state <= LOAD;
          end
        end
        LOAD: begin
          dbuf     <= bcd;
          overflow <= ovp;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic seen;
  // Position 0 is leftmost; the rightmost position is never blanked.
  always_comb begin
    blank = '0;
    seen  = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (dbuf[4*(NDIGITS-1-i) +: 4] != 4'd0)
        seen = 1'b1;
      blank[i] = !seen && (i != NDIGITS - 1);
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    dsel  = '0;
    bsel  = 1'b0;
    inrng = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (char_idx == IW'(i)) begin
        dsel  = dbuf[4*(NDIGITS-1-i) +: 4];
        bsel  = blank[i];
        inrng = 1'b1;
      end
    end
  end

  always_comb begin
    code_nxt = SPACE_CODE;
    if (inrng && !bsel) begin
      if (dsel <= 4'd9)
        code_nxt = DIGIT0_CODE + {3'b000, dsel};
      else
        code_nxt = ALPHA_CODE + {3'b000, dsel - 4'd10};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      char_code <= SPACE_CODE;
    else
      char_code <= code_nxt;
  end

endmodule

// File: doc/numb2str.md
NUMB2STR -- requirements
Module: numb2str

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 16, giving the binary input width in bits (4..32).
- REQ-002 The block SHALL have parameter NDIGITS, default 5, giving the number of displayed character positions (1..10).
- REQ-003 The block SHALL have parameter HEX, default 0, where 0 selects decimal and 1 selects hexadecimal conversion.
- REQ-004 The block SHALL have parameters DIGIT0_CODE (default 7'h30), ALPHA_CODE (default 7'h41) and SPACE_CODE (default 7'h20), giving the char codes for digit 0, hex digit A and blank.
- REQ-005 The block SHALL have these ports; it uses one clock, and its reset is asynchronous and active-high:
  - clk, input, 1: clock
  - rst, input, 1: asynchronous active-high reset
  - start, input, 1: conversion request
  - value, input, WIDTH: number to convert
  - busy, output, 1: conversion in progress
  - done, output, 1: one-cycle completion pulse
  - overflow, output, 1: last result did not fit in NDIGITS
  - char_idx, input, max(1,$clog2(NDIGITS)): requested position, where 0 is the leftmost (most significant) position
  - char_code, output, 7: char code for char_idx

Function
- REQ-006 The FSM SHALL have the states IDLE, CONVERT and LOAD.
- REQ-007 In IDLE, start=1 SHALL capture value at that edge and move to CONVERT; busy SHALL be 1 from the next cycle.
- REQ-008 When HEX=0, CONVERT SHALL run shift-add-3 (double-dabble) for exactly WIDTH cycles, one input bit per cycle, MSB first.
- REQ-009 When HEX=0, any 1 shifted out of the top BCD digit SHALL set a sticky overflow-pending bit.
- REQ-010 When HEX=1, CONVERT SHALL last 1 cycle, taking nibbles directly; overflow-pending SHALL be set if any captured bit at or above position 4*NDIGITS is 1.
- REQ-011 LOAD SHALL last 1 cycle and SHALL copy the digits and overflow-pending into the display buffer and the overflow output.
- REQ-012 During LOAD, done SHALL be 1, busy SHALL be 0, and the next state SHALL be IDLE.
- REQ-013 done SHALL rise WIDTH+1 cycles (HEX=0) or 2 cycles (HEX=1) after the start-sampling edge.
- REQ-014 start SHALL be ignored while busy=1 or during LOAD; no queuing.
- REQ-015 The display buffer SHALL be double-buffered: char_code SHALL reflect the previous result until LOAD completes.
- REQ-016 On overflow, the buffer SHALL hold the low NDIGITS digits and overflow SHALL be 1; otherwise overflow SHALL be 0.
- REQ-017 char_code SHALL be registered with 1-cycle latency from char_idx, independent of FSM state.
- REQ-018 Digit d at char_idx SHALL map to DIGIT0_CODE+d for d<=9 and to ALPHA_CODE+(d-10) for d in 10..15.
- REQ-019 A char_idx >= NDIGITS SHALL produce SPACE_CODE.

Reset
- REQ-020 rst=1 SHALL immediately force the FSM to IDLE, busy=0, done=0 and overflow=0.
- REQ-021 rst=1 SHALL immediately clear the display buffer to all zeros and force char_code to SPACE_CODE.
- REQ-022 A reset during CONVERT SHALL abort the conversion with no done pulse and no buffer update.

Configuration
- REQ-023 With LEADING_ZERO_BLANK_EN defined, zero digits left of the first nonzero digit SHALL output SPACE_CODE.
- REQ-024 With LEADING_ZERO_BLANK_EN defined, the rightmost position SHALL always show its digit (value 0 shows "0").
- REQ-025 With LEADING_ZERO_BLANK_EN undefined, every position SHALL show its digit, including leading zeros.

Verification
- REQ-026 Decimal (WIDTH=16, NDIGITS=5): value=12345 with start pulse -> done 17 cycles later; idx 0..4 give 31,32,33,34,35 hex; overflow=0.
- REQ-027 Decimal, NDIGITS=4: value=65535 -> overflow=1; idx 0..3 give "5535".
- REQ-028 Blanking: value=42 with LEADING_ZERO_BLANK_EN -> "   42"; without the macro -> "00042"; value=0 with the macro -> "    0".
- REQ-029 Hex (HEX=1, WIDTH=16, NDIGITS=4): value=16'hBEEF -> done 2 cycles after start; output "BEEF" (42,45,45,46 hex).
- REQ-030 Robustness: start re-pulsed mid-CONVERT is ignored (single done).
- REQ-031 Robustness: rst asserted at conversion cycle 8 -> no done, buffer all zeros, char_code=SPACE_CODE.
- REQ-032 Robustness: during a second conversion, char_code still shows the first result until the second done.
